// File: rtl/add_stream_lanes_pkg.sv
// Shared types and helpers for the streaming residual adder.
package add_stream_lanes_pkg;

    typedef enum logic [0:0] {
        ADD_WRAP = 1'b0,
        ADD_SAT  = 1'b1
    } add_mode_e;

    // Counter width that still works for a count of one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_stream_lanes_if.sv
// Operand/result stream bundle of the streaming residual adder.
interface add_stream_lanes_if #(
    parameter int unsigned LANES        = 16,
    parameter int unsigned WIDTH_ADDEND = 8,
    parameter int unsigned WIDTH_SUM    = 8
);
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES*WIDTH_ADDEND-1:0] addend1;
    logic [LANES*WIDTH_ADDEND-1:0] addend2;
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES*WIDTH_SUM-1:0]    sum;
    logic                          out_last_row;
    logic                          out_last;

    modport master (
        output in_valid, addend1, addend2, out_ready,
        input  in_ready, out_valid, sum, out_last_row, out_last
    );

    modport slave (
        input  in_valid, addend1, addend2, out_ready,
        output in_ready, out_valid, sum, out_last_row, out_last
    );
endinterface

// File: rtl/add_stream_lanes_lane_fmt.sv
// One lane: exact (WIDTH_ADDEND+1)-bit sum to wrapped or saturated WIDTH_SUM result plus overflow.
module add_stream_lanes_lane_fmt
    import add_stream_lanes_pkg::*;
#(
    parameter int unsigned WIDTH_ADDEND = 8,
    parameter int unsigned WIDTH_SUM    = 8
) (
    input  logic [WIDTH_ADDEND:0]  exact_i,
    input  add_mode_e              mode_i,
    output logic [WIDTH_SUM-1:0]   sum_o,
    output logic                   ovf_o
);
    localparam int unsigned ExW  = WIDTH_ADDEND + 1;
    localparam int unsigned ExtW = (ExW > WIDTH_SUM) ? ExW : WIDTH_SUM;

    localparam logic signed [ExtW-1:0] MaxV =
        {{(ExtW - WIDTH_SUM + 1){1'b0}}, {(WIDTH_SUM - 1){1'b1}}};
    localparam logic signed [ExtW-1:0] MinV = ~MaxV;

    logic signed [ExtW-1:0] ext;
    logic                   hi;
    logic                   lo;

    always_comb begin
        ext   = ExtW'($signed(exact_i));
        hi    = (ext > MaxV);
        lo    = (ext < MinV);
        ovf_o = hi | lo;
        sum_o = ext[WIDTH_SUM-1:0];
        if (mode_i == ADD_SAT) begin
            if (hi) begin
                sum_o = MaxV[WIDTH_SUM-1:0];
            end else if (lo) begin
                sum_o = MinV[WIDTH_SUM-1:0];
            end
        end
    end
endmodule

// File: rtl/add_stream_lanes.sv
// Streaming residual adder: LANES signed adds per beat, 2-stage valid/ready pipeline,
// row/tensor framing, per-tensor wrap/saturate mode and sticky overflow flag.
module add_stream_lanes
    import add_stream_lanes_pkg::*;
#(
    parameter int unsigned ADDER_NUM    = 128,
    parameter int unsigned DIMENTION    = 768,
    parameter int unsigned LANES        = 16,
    parameter int unsigned WIDTH_ADDEND = 8,
    parameter int unsigned WIDTH_SUM    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sat_mode,
    output logic              ovf_flag,
    add_stream_lanes_if.slave bus
);
    localparam int unsigned Beats = DIMENTION / LANES;
    localparam int unsigned BeatW = cnt_width(Beats);
    localparam int unsigned RowW  = cnt_width(ADDER_NUM);
    localparam int unsigned ExW   = WIDTH_ADDEND + 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);
    localparam logic [RowW-1:0]  LastRow  = RowW'(ADDER_NUM - 1);

    if (DIMENTION % LANES != 0) begin : g_dim_chk
        $error("DIMENTION must be a multiple of LANES");
    end
    if (WIDTH_SUM < WIDTH_ADDEND) begin : g_width_chk
        $error("WIDTH_SUM must be >= WIDTH_ADDEND");
    end

    logic                       s1_v_q;
    logic [LANES*ExW-1:0]       s1_sum_q;
    add_mode_e                  s1_mode_q;
    logic                       s2_v_q;
    logic [LANES*WIDTH_SUM-1:0] s2_sum_q;
    logic                       s2_ovf_q;
    add_mode_e                  mode_q, mode_d;
    logic [BeatW-1:0]           in_beat_q, in_beat_d, out_beat_q, out_beat_d;
    logic [RowW-1:0]            in_row_q, in_row_d, out_row_q, out_row_d;
    logic                       ovf_q, ovf_d;

    logic                       s2_ready, in_ready, in_fire, out_fire;
    logic                       in_first, out_first;
    add_mode_e                  beat_mode;
    logic [LANES*ExW-1:0]       exact;
    logic [LANES*WIDTH_SUM-1:0] fmt_sum;
    logic [LANES-1:0]           lane_ovf;

    assign s2_ready  = !s2_v_q || bus.out_ready;
    assign in_ready  = !s1_v_q || s2_ready;
    assign in_fire   = bus.in_valid && in_ready;
    assign out_fire  = s2_v_q && bus.out_ready;
    assign in_first  = (in_beat_q == '0) && (in_row_q == '0);
    assign out_first = (out_beat_q == '0) && (out_row_q == '0);
    // Mode is taken live only on a tensor's first beat, otherwise the latched copy.
    assign beat_mode = in_first ? add_mode_e'(sat_mode) : mode_q;

    always_comb begin
        exact = '0;
        for (int k = 0; k < LANES; k++) begin
            exact[k*ExW +: ExW] =
                {bus.addend1[k*WIDTH_ADDEND + WIDTH_ADDEND - 1],
                 bus.addend1[k*WIDTH_ADDEND +: WIDTH_ADDEND]} +
                {bus.addend2[k*WIDTH_ADDEND + WIDTH_ADDEND - 1],
                 bus.addend2[k*WIDTH_ADDEND +: WIDTH_ADDEND]};
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        add_stream_lanes_lane_fmt #(
            .WIDTH_ADDEND (WIDTH_ADDEND),
            .WIDTH_SUM    (WIDTH_SUM)
        ) u_fmt (
            .exact_i (s1_sum_q[k*ExW +: ExW]),
            .mode_i  (s1_mode_q),
            .sum_o   (fmt_sum[k*WIDTH_SUM +: WIDTH_SUM]),
            .ovf_o   (lane_ovf[k])
        );
    end

    always_comb begin
        in_beat_d  = in_beat_q;
        in_row_d   = in_row_q;
        out_beat_d = out_beat_q;
        out_row_d  = out_row_q;
        mode_d     = mode_q;
        ovf_d      = ovf_q;
        if (in_fire) begin
            if (in_first) begin
                mode_d = add_mode_e'(sat_mode);
            end
            if (in_beat_q == LastBeat) begin
                in_beat_d = '0;
                in_row_d  = (in_row_q == LastRow) ? '0 : in_row_q + RowW'(1);
            end else begin
                in_beat_d = in_beat_q + BeatW'(1);
            end
        end
        if (out_fire) begin
            // The first beat of a tensor restarts the sticky flag.
            ovf_d = (out_first ? 1'b0 : ovf_q) | s2_ovf_q;
            if (out_beat_q == LastBeat) begin
                out_beat_d = '0;
                out_row_d  = (out_row_q == LastRow) ? '0 : out_row_q + RowW'(1);
            end else begin
                out_beat_d = out_beat_q + BeatW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s1_sum_q   <= '0;
            s1_mode_q  <= ADD_WRAP;
            s2_v_q     <= 1'b0;
            s2_sum_q   <= '0;
            s2_ovf_q   <= 1'b0;
            mode_q     <= ADD_WRAP;
            in_beat_q  <= '0;
            in_row_q   <= '0;
            out_beat_q <= '0;
            out_row_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_v_q <= bus.in_valid;
                if (in_fire) begin
                    s1_sum_q  <= exact;
                    s1_mode_q <= beat_mode;
                end
            end
            if (s2_ready) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    s2_sum_q <= fmt_sum;
                    s2_ovf_q <= |lane_ovf;
                end
            end
            mode_q     <= mode_d;
            in_beat_q  <= in_beat_d;
            in_row_q   <= in_row_d;
            out_beat_q <= out_beat_d;
            out_row_q  <= out_row_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = s2_v_q;
    assign bus.sum          = s2_sum_q;
    assign bus.out_last_row = s2_v_q && (out_beat_q == LastBeat);
    assign bus.out_last     = bus.out_last_row && (out_row_q == LastRow);
    assign ovf_flag         = ovf_q;
endmodule

// File: tb/tb_add_stream_lanes.sv
// Bench for add_stream_lanes: 4 lanes x 8 bit, 2 beats/row, 2 rows; WS=8 and WS=9 instances.
module tb_add_stream_lanes;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sat_a = 1'b0;
    logic sat_b = 1'b0;
    logic ovf_a, ovf_b;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    add_stream_lanes_if #(.LANES(4), .WIDTH_ADDEND(8), .WIDTH_SUM(8)) ifa ();
    add_stream_lanes_if #(.LANES(4), .WIDTH_ADDEND(8), .WIDTH_SUM(9)) ifb ();

    add_stream_lanes #(
        .ADDER_NUM(2), .DIMENTION(8), .LANES(4), .WIDTH_ADDEND(8), .WIDTH_SUM(8)
    ) dut_a (
        .clk(clk), .rst(rst), .sat_mode(sat_a), .ovf_flag(ovf_a), .bus(ifa)
    );

    add_stream_lanes #(
        .ADDER_NUM(2), .DIMENTION(8), .LANES(4), .WIDTH_ADDEND(8), .WIDTH_SUM(9)
    ) dut_b (
        .clk(clk), .rst(rst), .sat_mode(sat_b), .ovf_flag(ovf_b), .bus(ifb)
    );

    typedef struct {
        bit          sat;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          ovf;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        bit          ovf;
    } exp_t;

    vec_t tbl[5];
    exp_t sb_q[$];
    bit   model_flag;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] beat_model(input logic [31:0] a, input logic [31:0] b,
                                               input bit sat);
        logic [31:0] s;
        bit          o;
        int          sa, sb, t;
        s = '0;
        o = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sa = $signed(a[k*8 +: 8]);
            sb = $signed(b[k*8 +: 8]);
            t  = sa + sb;
            if (t > 127 || t < -128) o = 1'b1;
            if (sat && t > 127)       s[k*8 +: 8] = 8'h7F;
            else if (sat && t < -128) s[k*8 +: 8] = 8'h80;
            else                      s[k*8 +: 8] = t[7:0];
        end
        return {o, s};
    endfunction

    // One full tensor (4 beats) back-to-back; flip toggles sat_mode after the first beat.
    task automatic run_tensor_a(input vec_t v, input bit flip, input string tag);
        int j;
        ifa.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c < 4) begin
                ifa.in_valid = 1'b1;
                ifa.addend1  = v.a;
                ifa.addend2  = v.b;
                sat_a        = (flip && c > 0) ? ~v.sat : v.sat;
            end else begin
                ifa.in_valid = 1'b0;
            end
            @(negedge clk);
            if (c >= 2) begin
                j = c - 2;
                chk($sformatf("%s_b%0d_valid", tag, j), ifa.out_valid, 1);
                chk($sformatf("%s_b%0d_sum", tag, j), ifa.sum, v.exp);
                chk($sformatf("%s_b%0d_last_row", tag, j), ifa.out_last_row, (j % 2) == 1);
                chk($sformatf("%s_b%0d_last", tag, j), ifa.out_last, j == 3);
            end else begin
                chk($sformatf("%s_c%0d_idle", tag, c), ifa.out_valid, 0);
            end
        end
        @(posedge clk); #1;
        chk({tag, "_ovf_flag"}, ovf_a, v.ovf);
        chk({tag, "_drained"}, ifa.out_valid, 0);
    endtask

    task automatic rand_driver(input int n);
        int          sent = 0;
        int          cyc = 0;
        bit          mode = 1'b0;
        logic [32:0] m;
        while (sent < n && cyc < 2000) begin
            @(posedge clk); #1;
            ifa.in_valid = ($urandom_range(0, 1) == 1);
            ifa.addend1  = $urandom;
            ifa.addend2  = $urandom;
            sat_a        = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (ifa.in_valid && ifa.in_ready) begin
                if (sent % 4 == 0) mode = sat_a;
                m = beat_model(ifa.addend1, ifa.addend2, mode);
                sb_q.push_back('{sum: m[31:0], ovf: m[32]});
                sent++;
            end
            cyc++;
        end
        chk("rand_drv_sent", sent, n);
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
    endtask

    task automatic rand_monitor(input int n);
        int          rcv = 0;
        int          cyc = 0;
        bit          prev_stall = 1'b0;
        logic [31:0] prev_sum = '0;
        bit          flag;
        exp_t        e;
        flag = model_flag;
        while (rcv < n && cyc < 3000) begin
            @(posedge clk); #1;
            ifa.out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (prev_stall) begin
                chk("stall_valid", ifa.out_valid, 1);
                chk("stall_sum", ifa.sum, prev_sum);
            end
            chk("rand_ovf_flag", ovf_a, flag);
            if (ifa.out_valid && ifa.out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rand_unexpected_beat: got sum 0x%0h with empty scoreboard",
                             ifa.sum);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("rand_sum_%0d", rcv), ifa.sum, e.sum);
                    chk($sformatf("rand_last_row_%0d", rcv), ifa.out_last_row, (rcv % 2) == 1);
                    chk($sformatf("rand_last_%0d", rcv), ifa.out_last, (rcv % 4) == 3);
                    flag = ((rcv % 4 == 0) ? 1'b0 : flag) | e.ovf;
                end
                rcv++;
            end
            prev_stall = ifa.out_valid && !ifa.out_ready;
            prev_sum   = ifa.sum;
            cyc++;
        end
        chk("rand_mon_rcvd", rcv, n);
        @(posedge clk); #1;
        ifa.out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0] exp_b;
        tbl[0] = '{sat: 1'b0, a: 32'h0100FD64, b: 32'h01000232, exp: 32'h0200FF96, ovf: 1'b1};
        tbl[1] = '{sat: 1'b1, a: 32'h807F9C64, b: 32'h0000CE32, exp: 32'h807F807F, ovf: 1'b1};
        tbl[2] = '{sat: 1'b1, a: 32'h3CFD807F, b: 32'h43020000, exp: 32'h7FFF807F, ovf: 1'b0};
        tbl[3] = '{sat: 1'b0, a: 32'hC0400580, b: 32'hC03FF97F, exp: 32'h807FFEFF, ovf: 1'b0};
        tbl[4] = '{sat: 1'b0, a: 32'h00000080, b: 32'h000000FF, exp: 32'h0000007F, ovf: 1'b1};

        ifa.in_valid = 1'b0; ifa.addend1 = '0; ifa.addend2 = '0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.addend1 = '0; ifb.addend2 = '0; ifb.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_sum", ifa.sum, 0);
        chk("rst_last_row", ifa.out_last_row, 0);
        chk("rst_last", ifa.out_last, 0);
        chk("rst_ovf_flag", ovf_a, 0);
        chk("rst_b_out_valid", ifb.out_valid, 0);

        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 5; i++) begin
                run_tensor_a(tbl[i], pass == 1, $sformatf("tbl%0d_p%0d", i, pass));
            end
        end

        model_flag = tbl[4].ovf;
        fork
            rand_driver(40);
            rand_monitor(40);
        join

        // Wider result: nothing can overflow, mode toggles are irrelevant.
        exp_b = {9'h1FF, 9'h096, 9'h100, 9'h0FE};
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c < 4) begin
                ifb.in_valid = 1'b1;
                ifb.addend1  = 32'hFD64807F;
                ifb.addend2  = 32'h0232807F;
                sat_b        = c[0];
            end else begin
                ifb.in_valid = 1'b0;
            end
            @(negedge clk);
            if (c >= 2) begin
                chk($sformatf("ws9_b%0d_valid", c - 2), ifb.out_valid, 1);
                chk($sformatf("ws9_b%0d_sum", c - 2), ifb.sum, exp_b);
                chk($sformatf("ws9_b%0d_last", c - 2), ifb.out_last, c == 5);
            end
        end
        @(posedge clk); #1;
        chk("ws9_ovf_flag", ovf_b, 0);

        // Reset after three of four beats; the next tensor must start at beat 0.
        ifa.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (c < 3) begin
                ifa.in_valid = 1'b1;
                ifa.addend1  = tbl[0].a;
                ifa.addend2  = tbl[0].b;
                sat_a        = 1'b0;
            end else begin
                ifa.in_valid = 1'b0;
                rst          = 1'b1;
            end
            @(negedge clk);
        end
        chk("midrst_pre_ovf", ovf_a, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", ifa.out_valid, 0);
        chk("midrst_ovf_flag", ovf_a, 0);
        chk("midrst_sum", ifa.sum, 0);
        run_tensor_a(tbl[3], 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
